// File: rtl/fcl_mac_engine.sv
// fcl_mac_engine: fully-connected layer y = act(W*x + b) on one shared MAC, weights/bias in writable RAM.
module fcl_mac_engine #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 10,
  parameter int ACC_W = 40,
  parameter int AW    = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  relu_en,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         w_data,
  output logic                  w_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*DW-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*DW-1:0]   out_data,
  output logic                  busy
);
  localparam int NW = N_OUT*(N_IN+1);
  localparam int IW = $clog2(N_IN+1);
  localparam int XW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 <<< (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;
  typedef enum logic [1:0] {IDLE, MAC, POST, DONE} state_t;
  state_t                   state_q, state_d;
  logic [OW-1:0]            o_q, o_d;
  logic [IW-1:0]            i_q, i_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     relu_q, relu_d;
  logic                     w_err_q, w_err_d;
  logic signed [DW-1:0]     x_q [N_IN];
  logic signed [DW-1:0]     x_d [N_IN];
  logic signed [DW-1:0]     y_q [N_OUT];
  logic signed [DW-1:0]     y_d [N_OUT];
  logic signed [DW-1:0]     mem [NW];
  logic [AW-1:0]            rd_addr;
  logic signed [DW-1:0]     w_rd, x_cur, sat;
  logic signed [2*DW-1:0]   mul;
  logic signed [ACC_W-1:0]  term, r, rr;
  assign rd_addr   = AW'(int'(o_q) * (N_IN+1) + int'(i_q));
  assign w_rd      = mem[rd_addr];
  assign x_cur     = x_q[i_q[XW-1:0]];
  assign mul       = (2*DW)'(w_rd) * (2*DW)'(x_cur);
  // The bias slot is pre-scaled so it lands on the same binary point as the products.
  assign term      = (i_q == IW'(N_IN)) ? ACC_W'(w_rd) <<< FRAC : ACC_W'(mul);
  assign r         = acc_q >>> FRAC;
  assign rr        = (relu_q && r[ACC_W-1]) ? '0 : r;
  assign sat       = (rr > MAXV) ? DW'(MAXV) : (rr < MINV) ? DW'(MINV) : DW'(rr);
  assign w_err_d   = w_we && state_q != IDLE;
  assign w_err     = w_err_q;
  assign busy      = state_q != IDLE;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_data[g*DW +: DW] = y_q[g];
  end
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    acc_d   = acc_q;
    relu_d  = relu_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (in_valid) begin
        for (int k = 0; k < N_IN; k++) x_d[k] = in_data[k*DW +: DW];
        relu_d  = relu_en;
        o_d     = '0;
        i_d     = '0;
        acc_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_q + term;
        i_d     = i_q + 1'b1;
        state_d = (i_q == IW'(N_IN)) ? POST : MAC;
      end
      POST: begin
        y_d[o_q] = sat;
        acc_d    = '0;
        i_d      = '0;
        o_d      = (o_q == OW'(N_OUT-1)) ? o_q : o_q + 1'b1;
        state_d  = (o_q == OW'(N_OUT-1)) ? DONE : MAC;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      o_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      relu_q  <= 1'b0;
      w_err_q <= 1'b0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      relu_q  <= relu_d;
      w_err_q <= w_err_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
  // Coefficient RAM survives reset; writes only land while idle and in range.
  always_ff @(posedge clk) begin
    if (w_we && state_q == IDLE && w_addr < AW'(NW)) mem[w_addr] <= w_data;
  end
endmodule
